sd_cache_port_arbiter: RTL and testbench

//  Shares the single SD/DDR cache access port between two requesters:

---
 rtl/sd_cache_port_arbiter_if.sv | 33 +++
 rtl/sd_cache_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sd_cache_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cache_port_arbiter_if.sv
// Requester and downstream cache-port signals shared by the two-port arbiter.
// slave = arbiter side, master = requesters plus the cache model.
interface sd_cache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        err;
  logic              busy;
  logic              down_re;
  logic              down_we;
  logic [ADDR_W-1:0] down_addr;
  logic [DATA_W-1:0] down_wdata;
  logic [DATA_W-1:0] down_rdata;
  logic              down_done;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, down_rdata, down_done,
    output ack, rdata, err, busy, down_re, down_we, down_addr, down_wdata
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, down_rdata, down_done,
    input  ack, rdata, err, busy, down_re, down_we, down_addr, down_wdata
  );
endinterface

// File: rtl/sd_cache_port_arbiter.sv
// Two-port round-robin arbiter in front of the SD/DDR cache port: IDLE->ISSUE->WAIT->RESP.
// Optional macro ARB_TIMEOUT_EN forces completion with err after TIMEOUT cycles in WAIT.
module sd_cache_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 4096
`endif
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  sd_cache_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              g_q, g_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          // On a tie the port that was not served last wins.
          g_d     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          we_d    = g_d ? bus.we[1] : bus.we[0];
          addr_d  = g_d ? bus.addr1 : bus.addr0;
          wdata_d = g_d ? bus.wdata1 : bus.wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
        err_d = 1'b0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.down_done) begin
          rdata_d = we_q ? '0 : bus.down_rdata;
          state_d = S_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        last_d  = g_q;
        rdata_d = '0;
`ifdef ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.down_re    = (state_q == S_ISSUE) && !we_q;
  assign bus.down_we    = (state_q == S_ISSUE) && we_q;
  assign bus.down_addr  = addr_q;
  assign bus.down_wdata = wdata_q;
  assign bus.rdata      = rdata_q;
  assign bus.ack        = (state_q == S_RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef ARB_TIMEOUT_EN
  assign bus.err = (state_q == S_RESP && err_q) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
`else
  assign bus.err = 2'b00;
`endif

endmodule

// File: tb/tb_sd_cache_port_arbiter.sv
// Bench for sd_cache_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_sd_cache_port_arbiter;

  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sd_cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
  sd_cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(bus.slave));
`else
  sd_cache_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(bus.slave));
`endif

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.down_rdata = '0; bus.down_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic snap(output logic [31:0] o[8]);
    o[0] = 32'(bus.ack);     o[1] = bus.rdata;   o[2] = 32'(bus.err);   o[3] = 32'(bus.busy);
    o[4] = 32'(bus.down_re); o[5] = 32'(bus.down_we); o[6] = bus.down_addr; o[7] = bus.down_wdata;
  endtask

  task automatic test_reset();
    logic [31:0] o[8];
    string nm[8] = '{"ack", "rdata", "err", "busy", "down_re", "down_we", "down_addr", "down_wdata"};
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_in);
    snap(o);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (o[i] !== 32'd0) begin
        n_fail++; $display("FAIL reset_%s: got %h expected 0", nm[i], o[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk_in);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  // Scenario: single read on port 0, done 5 cycles after the strobe.
  task automatic test_single_read();
    int n_re = 0, n_we = 0, strobe_c = -1, ack_c = -1;
    logic [1:0] ack_v = 2'b00;
    logic [31:0] ack_rd = '0;
    do_reset();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h10010004;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk_in);
      bus.down_done = 1'b0; bus.down_rdata = 32'hDEADBEEF;
      if (bus.down_re) begin n_re++; strobe_c = c; end
      if (bus.down_we) n_we++;
      if (strobe_c > 0 && c == strobe_c + 5) begin
        bus.down_done = 1'b1; bus.down_rdata = 32'h12345678;
      end
      if (ack_c > 0 && c == ack_c + 1) begin
        n_tests++;
        if (bus.rdata !== 32'd0 || bus.ack !== 2'b00) begin
          n_fail++; $display("FAIL read_after_ack: got ack=%b rdata=%h expected 00/0", bus.ack, bus.rdata);
        end
      end
      if (bus.ack !== 2'b00 && ack_c < 0) begin
        ack_c = c; ack_v = bus.ack; ack_rd = bus.rdata; bus.req = 2'b00;
      end
    end
    n_tests++;
    if (n_re != 1 || n_we != 0) begin
      n_fail++; $display("FAIL read_strobes: got re=%0d we=%0d expected 1/0", n_re, n_we);
    end
    n_tests++;
    if (ack_v !== 2'b01) begin
      n_fail++; $display("FAIL read_ack: got %b expected 01", ack_v);
    end
    n_tests++;
    if (ack_c + 1 != 3 + 5) begin
      n_fail++; $display("FAIL read_latency: got %0d expected %0d", ack_c + 1, 8);
    end
    n_tests++;
    if (ack_rd !== 32'h12345678) begin
      n_fail++; $display("FAIL read_rdata: got %h expected 12345678", ack_rd);
    end
  endtask

  // Scenario: single write on port 1; downstream data must be ignored.
  task automatic test_write();
    int n_re = 0, n_we = 0, strobe_c = -1, unstable = 0;
    bit got_ack = 0;
    logic [1:0] ack_v = 2'b00;
    logic [31:0] ack_rd = 32'hFFFFFFFF;
    do_reset();
    bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 32'h10010010; bus.wdata1 = 32'hA5A5A5A5;
    for (int c = 1; c < 40 && !got_ack; c++) begin
      @(negedge clk_in);
      bus.down_done = 1'b0;
      if (bus.down_re) n_re++;
      if (bus.down_we) begin n_we++; strobe_c = c; end
      if (strobe_c > 0 && c <= strobe_c + 3 &&
          (bus.down_addr !== 32'h10010010 || bus.down_wdata !== 32'hA5A5A5A5)) unstable++;
      if (strobe_c > 0 && c == strobe_c + 3) begin
        bus.down_done = 1'b1; bus.down_rdata = 32'h5555AAAA;
      end
      if (bus.ack !== 2'b00) begin
        got_ack = 1; ack_v = bus.ack; ack_rd = bus.rdata; bus.req = 2'b00; bus.we = 2'b00;
      end
    end
    n_tests++;
    if (n_we != 1 || n_re != 0) begin
      n_fail++; $display("FAIL write_strobes: got we=%0d re=%0d expected 1/0", n_we, n_re);
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL write_down_stable: got %0d unstable cycles expected 0", unstable);
    end
    n_tests++;
    if (ack_v !== 2'b10) begin
      n_fail++; $display("FAIL write_ack: got %b expected 10", ack_v);
    end
    n_tests++;
    if (ack_rd !== 32'd0) begin
      n_fail++; $display("FAIL write_rdata: got %h expected 0", ack_rd);
    end
  endtask

  // Scenario: both ports requesting from reset; grants must alternate starting at port 0.
  task automatic test_contention();
    logic [1:0] exp_order[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int n_ack = 0, ds_cnt = -1, low_run = 0, max_low = 0;
    bit started = 0;
    do_reset();
    bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 32'h100; bus.addr1 = 32'h200;
    for (int c = 0; c < 200 && n_ack < 4; c++) begin
      @(negedge clk_in);
      bus.down_done = 1'b0;
      if (bus.ack !== 2'b00) begin
        n_tests++;
        if (bus.ack !== exp_order[n_ack]) begin
          n_fail++; $display("FAIL contention_order%0d: got %b expected %b", n_ack, bus.ack, exp_order[n_ack]);
        end
        n_ack++;
      end
      if (bus.down_re) begin started = 1; ds_cnt = 2; end
      else if (ds_cnt > 0) begin
        ds_cnt--;
        if (ds_cnt == 0) begin bus.down_done = 1'b1; bus.down_rdata = 32'(c); end
      end
      if (started && n_ack < 4) begin
        low_run = bus.busy ? 0 : low_run + 1;
        if (low_run > max_low) max_low = low_run;
      end
    end
    bus.req = 2'b00;
    n_tests++;
    if (n_ack != 4) begin
      n_fail++; $display("FAIL contention_count: got %0d expected 4", n_ack);
    end
    n_tests++;
    if (max_low > 1) begin
      n_fail++; $display("FAIL contention_busy_gap: got %0d expected <=1", max_low);
    end
  endtask

  // Scenario: read with no downstream completion.
  task automatic test_timeout();
    int strobe_c = -1, ack_c = -1, busy_low = 0, n_ack = 0;
    logic [1:0] ack_v = 2'b00, err_v = 2'b00;
    logic [31:0] ack_rd = 32'hFFFFFFFF;
    do_reset();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h10010020;
    for (int c = 1; c < 120; c++) begin
      @(negedge clk_in);
      bus.down_done = 1'b0; bus.down_rdata = 32'hCAFEF00D;
      if (bus.down_re) strobe_c = c;
      if (strobe_c > 0 && !bus.busy && ack_c < 0) busy_low++;
      if (bus.ack !== 2'b00) begin
        n_ack++;
        if (ack_c < 0) begin
          ack_c = c; ack_v = bus.ack; err_v = bus.err; ack_rd = bus.rdata; bus.req = 2'b00;
        end
      end
      if (ack_c > 0 && c == ack_c + 1) bus.down_done = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    n_tests++;
    if (ack_v !== 2'b01 || err_v !== 2'b01) begin
      n_fail++; $display("FAIL timeout_ack_err: got ack=%b err=%b expected 01/01", ack_v, err_v);
    end
    n_tests++;
    if (ack_c != 2 + TB_TIMEOUT) begin
      n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", ack_c, 2 + TB_TIMEOUT);
    end
    n_tests++;
    if (ack_rd !== 32'd0) begin
      n_fail++; $display("FAIL timeout_rdata: got %h expected 0", ack_rd);
    end
    n_tests++;
    if (n_ack != 1) begin
      n_fail++; $display("FAIL timeout_late_done: got %0d acks expected 1", n_ack);
    end
`else
    n_tests++;
    if (n_ack != 0 || strobe_c != 1) begin
      n_fail++; $display("FAIL no_timeout_ack: got acks=%0d strobe=%0d expected 0/1", n_ack, strobe_c);
    end
    n_tests++;
    if (busy_low != 0) begin
      n_fail++; $display("FAIL no_timeout_busy: got %0d idle cycles expected 0", busy_low);
    end
`endif
    do_reset();
  endtask

  // Scenario: reset asserted while waiting for downstream completion.
  task automatic test_reset_mid_wait();
    logic [31:0] o[8];
    int strobe_c = -1, bad = 0;
    do_reset();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h10010030;
    for (int c = 1; c < 20 && strobe_c < 0; c++) begin
      @(negedge clk_in);
      if (bus.down_re) strobe_c = c;
    end
    n_tests++;
    if (strobe_c < 0) begin
      n_fail++; $display("FAIL rst_wait_strobe: got none expected strobe");
    end
    repeat (2) @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    snap(o);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (o[i] !== 32'd0) begin
        n_fail++; $display("FAIL rst_wait_out%0d: got %h expected 0", i, o[i]);
      end
    end
    bus.req = 2'b00;
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    bus.down_done = 1'b1; bus.down_rdata = 32'h77777777;
    @(negedge clk_in);
    bus.down_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (bus.ack !== 2'b00 || bus.busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_wait_after: got %0d bad cycles expected 0", bad);
    end
  endtask

  // Random traffic: each port holds a transaction until acked; a tie goes to the
  // port not served last; downstream answers 1..4 cycles after the strobe.
  task automatic test_random(input int n_txn);
    bit pend[2] = '{0, 0};
    logic wv[2];
    logic [31:0] av[2], dv[2];
    int age[2] = '{0, 0};
    logic [1:0] prev_req = 2'b00;
    int last = 1, ds_g = 0, ds_cnt = 0, n_done = 0, g;
    bit ds_act = 0, exp_ack = 0;
    logic [31:0] exp_rd = '0;
    do_reset();
    for (int c = 0; c < 20000 && n_done < n_txn; c++) begin
      @(negedge clk_in);
      bus.down_done = 1'b0; bus.down_rdata = $urandom;
      n_tests++;
      if (exp_ack) begin
        if (bus.ack !== 2'(1 << ds_g) || bus.rdata !== exp_rd || bus.err !== 2'b00) begin
          n_fail++; $display("FAIL rand_ack: got ack=%b rdata=%h err=%b expected %b/%h/00",
                             bus.ack, bus.rdata, bus.err, 2'(1 << ds_g), exp_rd);
        end
        pend[ds_g] = 0; last = ds_g; exp_ack = 0; n_done++;
      end else if (bus.ack !== 2'b00) begin
        n_fail++; $display("FAIL rand_spurious_ack: got %b expected 00", bus.ack);
      end
      if (bus.down_re || bus.down_we) begin
        g = (prev_req == 2'b11) ? 1 - last : (prev_req[1] ? 1 : 0);
        n_tests++;
        if (ds_act || prev_req == 2'b00 ||
            {bus.down_re, bus.down_we, bus.down_addr, bus.down_wdata} !== {!wv[g], wv[g], av[g], dv[g]}) begin
          n_fail++; $display("FAIL rand_grant: got re=%b we=%b addr=%h wdata=%h expected port %0d we=%b addr=%h wdata=%h",
                             bus.down_re, bus.down_we, bus.down_addr, bus.down_wdata, g, wv[g], av[g], dv[g]);
        end
        ds_act = 1; ds_g = g; ds_cnt = $urandom_range(1, 4);
        // A completion during the strobe cycle must be ignored.
        if ($urandom_range(0, 3) == 0) bus.down_done = 1'b1;
      end else if (ds_act) begin
        n_tests++;
        if (bus.down_addr !== av[ds_g] || bus.down_wdata !== dv[ds_g]) begin
          n_fail++; $display("FAIL rand_down_hold: got %h/%h expected %h/%h",
                             bus.down_addr, bus.down_wdata, av[ds_g], dv[ds_g]);
        end
        ds_cnt--;
        if (ds_cnt == 0) begin
          bus.down_done = 1'b1;
          exp_rd = wv[ds_g] ? 32'd0 : bus.down_rdata;
          ds_act = 0; exp_ack = 1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          age[p]++;
          if (age[p] == 100) begin
            n_tests++; n_fail++;
            $display("FAIL rand_starve: port %0d waited %0d cycles expected <100", p, age[p]);
          end
        end else if ($urandom_range(0, 2) != 0) begin
          pend[p] = 1; age[p] = 0;
          wv[p] = 1'($urandom_range(0, 1)); av[p] = $urandom; dv[p] = $urandom;
        end
      end
      bus.req = {pend[1], pend[0]};
      bus.we = {wv[1], wv[0]};
      bus.addr0 = av[0]; bus.addr1 = av[1]; bus.wdata0 = dv[0]; bus.wdata1 = dv[1];
      prev_req = bus.req;
    end
    n_tests++;
    if (n_done != n_txn) begin
      n_fail++; $display("FAIL rand_count: got %0d expected %0d", n_done, n_txn);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_random(300);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
